// File: rtl/mmcm_rst_seq.sv
// Reset and lock sequencer for the ADC board MMCM: drives the MMCM reset, qualifies lock,
// retries on timeout and releases the IDELAYCTRL and ADC/SPI resets in order.
module mmcm_rst_seq #(
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int SEQ_GAP_CYC      = 64,
    parameter int MAX_RETRY        = 7
) (
    input  logic       sys_clkr,
    input  logic       sys_rst_n,
    input  logic       mmcm_locked,
    input  logic       force_reset,
    output logic       mmcm_rst,
    output logic       idelay_rst,
    output logic       adc_rst_n,
    output logic       clk_ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_REL_IDELAY = 3'd3,
        ST_REL_ADC    = 3'd4,
        ST_RUN        = 3'd5,
        ST_FAULT      = 3'd6
    } state_t;

    state_t      state_q, state_nxt;
    logic        sync_q, lk;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] stable_cnt, stable_nxt;
    logic [3:0]  retry_nxt;
    logic [7:0]  loss_nxt;
    logic        entering;
    logic        mmcm_rst_nxt, idelay_rst_nxt, adc_rst_n_nxt, clk_ready_nxt, fault_nxt;

    assign state = state_q;

    always_comb begin
        state_nxt = state_q;
        retry_nxt = retry_cnt;
        loss_nxt  = lock_loss_cnt;
        case (state_q)
            ST_HOLD: begin
                if (cnt == 32'(RST_HOLD_CYC - 1)) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // The sample taken on the entry edge is not counted, so acceptance
                // lands LOCK_STABLE_CYC+2 cycles after entry at best.
                if (stable_cnt > 32'(LOCK_STABLE_CYC)) begin
                    state_nxt = ST_REL_IDELAY;
                end else if (cnt == 32'(LOCK_TIMEOUT_CYC - 1)) begin
                    retry_nxt = retry_cnt + 4'd1;
                    state_nxt = (retry_nxt == 4'(MAX_RETRY)) ? ST_FAULT : ST_HOLD;
                end
            end
            ST_REL_IDELAY: begin
                if (!lk) state_nxt = ST_HOLD;
                else if (cnt == 32'(SEQ_GAP_CYC - 1)) state_nxt = ST_REL_ADC;
            end
            ST_REL_ADC: begin
                if (!lk) state_nxt = ST_HOLD;
                else if (cnt == 32'(SEQ_GAP_CYC - 1)) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!lk) begin
                    state_nxt = ST_HOLD;
                    if (lock_loss_cnt != 8'hff) loss_nxt = lock_loss_cnt + 8'd1;
                end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_HOLD;
        endcase
        if (force_reset) begin
            state_nxt = ST_HOLD;
            retry_nxt = 4'd0;
            loss_nxt  = lock_loss_cnt;
        end
    end

    always_comb begin
        entering   = (state_nxt != state_q) || force_reset;
        cnt_nxt    = entering ? 32'd0 : cnt + 32'd1;
        stable_nxt = (entering || state_q != ST_WAIT_LOCK || !lk) ? 32'd0 : stable_cnt + 32'd1;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        mmcm_rst_nxt   = 1'b1;
        idelay_rst_nxt = 1'b1;
        adc_rst_n_nxt  = 1'b0;
        clk_ready_nxt  = 1'b0;
        fault_nxt      = 1'b0;
        case (state_nxt)
            ST_WAIT_LOCK:  mmcm_rst_nxt = 1'b0;
            ST_REL_IDELAY: begin
                mmcm_rst_nxt   = 1'b0;
                idelay_rst_nxt = 1'b0;
            end
            ST_REL_ADC: begin
                mmcm_rst_nxt   = 1'b0;
                idelay_rst_nxt = 1'b0;
                adc_rst_n_nxt  = 1'b1;
            end
            ST_RUN: begin
                mmcm_rst_nxt   = 1'b0;
                idelay_rst_nxt = 1'b0;
                adc_rst_n_nxt  = 1'b1;
                clk_ready_nxt  = 1'b1;
            end
            ST_FAULT: fault_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clkr or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q        <= 1'b0;
            lk            <= 1'b0;
            state_q       <= ST_HOLD;
            cnt           <= 32'd0;
            stable_cnt    <= 32'd0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
            mmcm_rst      <= 1'b1;
            idelay_rst    <= 1'b1;
            adc_rst_n     <= 1'b0;
            clk_ready     <= 1'b0;
            fault         <= 1'b0;
        end else begin
            sync_q        <= mmcm_locked;
            lk            <= sync_q;
            state_q       <= state_nxt;
            cnt           <= cnt_nxt;
            stable_cnt    <= stable_nxt;
            retry_cnt     <= retry_nxt;
            lock_loss_cnt <= loss_nxt;
            mmcm_rst      <= mmcm_rst_nxt;
            idelay_rst    <= idelay_rst_nxt;
            adc_rst_n     <= adc_rst_n_nxt;
            clk_ready     <= clk_ready_nxt;
            fault         <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_mmcm_rst_seq.sv
// Directed bench for mmcm_rst_seq: bring-up, lock glitch, timeout/fault, lock loss and async reset.
module tb_mmcm_rst_seq;

    logic       sys_clkr = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       mmcm_locked = 1'b0;
    logic       force_reset = 1'b0;
    logic       mmcm_rst, idelay_rst, adc_rst_n, clk_ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    mmcm_rst_seq #(
        .RST_HOLD_CYC(4), .LOCK_TIMEOUT_CYC(100), .LOCK_STABLE_CYC(8),
        .SEQ_GAP_CYC(4), .MAX_RETRY(2)
    ) dut (
        .sys_clkr(sys_clkr), .sys_rst_n(sys_rst_n), .mmcm_locked(mmcm_locked),
        .force_reset(force_reset), .mmcm_rst(mmcm_rst), .idelay_rst(idelay_rst),
        .adc_rst_n(adc_rst_n), .clk_ready(clk_ready), .fault(fault),
        .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt), .state(state)
    );

    always #5 sys_clkr = ~sys_clkr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic mr,
                              input logic ir, input logic an, input logic cr, input logic f);
        check_eq({tag, ".state"}, 32'(state), 32'(st));
        check_eq({tag, ".mmcm_rst"}, 32'(mmcm_rst), 32'(mr));
        check_eq({tag, ".idelay_rst"}, 32'(idelay_rst), 32'(ir));
        check_eq({tag, ".adc_rst_n"}, 32'(adc_rst_n), 32'(an));
        check_eq({tag, ".clk_ready"}, 32'(clk_ready), 32'(cr));
        check_eq({tag, ".fault"}, 32'(fault), 32'(f));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clkr);
        #1;
    endtask

    // Leaves the bench 1 ns after edge E0; the first HOLD edge is E1.
    task automatic do_reset(input logic locked);
        sys_rst_n   = 1'b0;
        mmcm_locked = locked;
        force_reset = 1'b0;
        step(1);
        check_outs("rst", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst.retry", 32'(retry_cnt), 32'd0);
        check_eq("rst.loss", 32'(lock_loss_cnt), 32'd0);
        step(2);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        // Nominal bring-up, then lock loss in RUN
        do_reset(1'b1);
        step(3);  check_outs("nom.e3", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);  check_outs("nom.e4", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(9);  check_outs("nom.e13", 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);  check_outs("nom.e14", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3);  check_eq("nom.e17.adc", 32'(adc_rst_n), 32'd0);
        step(1);  check_outs("nom.e18", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3);  check_eq("nom.e21.rdy", 32'(clk_ready), 32'd0);
        step(1);  check_outs("nom.e22", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(8);  mmcm_locked = 1'b0;
        step(2);  check_outs("loss.e32", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);  check_outs("loss.e33", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("loss.cnt", 32'(lock_loss_cnt), 32'd1);
        check_eq("loss.retry", 32'(retry_cnt), 32'd0);
        step(7);  mmcm_locked = 1'b1;
        step(19); check_eq("reseq.e59.state", 32'(state), 32'd4);
        step(1);  check_outs("reseq.e60", 3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("reseq.loss", 32'(lock_loss_cnt), 32'd1);

        // Asynchronous reset mid-RUN, fresh bring-up, lock loss in REL_ADC
        step(2);
        sys_rst_n = 1'b0;
        #1;
        check_outs("arst", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("arst.loss", 32'(lock_loss_cnt), 32'd0);
        check_eq("arst.retry", 32'(retry_cnt), 32'd0);
        #3;
        sys_rst_n = 1'b1;
        step(18); check_outs("radc.e18", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        mmcm_locked = 1'b0;
        step(2);  check_eq("radc.e20.state", 32'(state), 32'd4);
        step(1);  check_outs("radc.e21", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("radc.loss", 32'(lock_loss_cnt), 32'd0);

        // One-cycle lock glitch in WAIT_LOCK restarts the stable count
        do_reset(1'b1);
        step(4);  check_eq("glitch.e4.state", 32'(state), 32'd2);
        step(5);  mmcm_locked = 1'b0;
        step(1);  mmcm_locked = 1'b1;
        step(4);  check_eq("glitch.e14.state", 32'(state), 32'd2);
        step(7);  check_eq("glitch.e21.state", 32'(state), 32'd2);
        step(1);  check_outs("glitch.e22", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Lock never arrives: two timeouts, FAULT, then force_reset
        do_reset(1'b0);
        step(103); check_eq("to1.e103.state", 32'(state), 32'd2);
        check_eq("to1.e103.retry", 32'(retry_cnt), 32'd0);
        step(1);   check_outs("to1.e104", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("to1.retry", 32'(retry_cnt), 32'd1);
        step(103); check_eq("to2.e207.state", 32'(state), 32'd2);
        step(1);   check_outs("to2.e208", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("to2.retry", 32'(retry_cnt), 32'd2);
        step(10);  check_outs("fault.hold", 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        force_reset = 1'b1;
        step(1);   force_reset = 1'b0;
        check_outs("force", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("force.retry", 32'(retry_cnt), 32'd0);
        step(4);   check_eq("force.e4.state", 32'(state), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmcm_rst_seq.md
# mmcm_rst_seq

Reset and lock sequencer for the ADC board MMCM that derives the 200 MHz, 10 MHz and 5 MHz SPI clocks from the 50 MHz system clock. It drives the MMCM reset, qualifies the lock signal, retries on lock timeout and recovers from lock loss. Once the clocks are stable it releases downstream resets in order: IDELAYCTRL reset in the 200 MHz domain first, then the ADC/SPI reset. It runs entirely in the buffered system clock domain.

## Interface
- RST_HOLD_CYC, 16: number of cycles `mmcm_rst` is held high per reset attempt.
- LOCK_TIMEOUT_CYC, 50000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- LOCK_STABLE_CYC, 1024: consecutive synchronized-high `mmcm_locked` cycles required to accept lock.
- SEQ_GAP_CYC, 64: cycles between successive downstream reset releases.
- MAX_RETRY, 7: number of failed attempts before entering FAULT (1..15).

Ports:
- sys_clkr  in  1  system clock, 50 MHz, BUFG-driven.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- mmcm_locked  in  1  MMCM locked output; asynchronous to `sys_clkr`.
- force_reset  in  1  single-cycle request to restart the sequence from any state.
- mmcm_rst  out  1  MMCM reset, active-high.
- idelay_rst  out  1  IDELAYCTRL reset, active-high.
- adc_rst_n  out  1  ADC/SPI logic reset, active-low.
- clk_ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  4  failed attempts since the last reset or `force_reset`.
- lock_loss_cnt  out  8  lock-loss events in RUN, saturating at 255; cleared only by `sys_rst_n`.
- state  out  3  current state encoding, for debug.

## Operation
- `mmcm_locked` passes through a 2-FF synchronizer; `lk` denotes the synchronized value.
- All outputs are registered and update on the same edge as the state register. Outputs are a pure function of state, except the counters.
- State encodings and output values (mmcm_rst / idelay_rst / adc_rst_n / clk_ready / fault):
  - HOLD = 1: outputs 1/1/0/0/0. Stays for exactly RST_HOLD_CYC cycles, then goes to WAIT_LOCK.
  - WAIT_LOCK = 2: outputs 0/1/0/0/0.
    - A cycle counter counts from 0.
    - A stable counter increments while `lk` = 1 and clears to 0 when `lk` = 0.
    - When the stable counter reaches LOCK_STABLE_CYC, go to REL_IDELAY.
    - Otherwise, when the cycle counter reaches LOCK_TIMEOUT_CYC-1, increment `retry_cnt`. If the new value equals MAX_RETRY, go to FAULT; else go to HOLD.
    - If lock acceptance and timeout occur in the same cycle, lock acceptance wins.
  - REL_IDELAY = 3: outputs 0/0/0/0/0. Lasts SEQ_GAP_CYC cycles, then goes to REL_ADC.
  - REL_ADC = 4: outputs 0/0/1/0/0. Lasts SEQ_GAP_CYC cycles, then goes to RUN.
  - RUN = 5: outputs 0/0/1/1/0. Stays until lock loss or `force_reset`.
  - FAULT = 6: outputs 1/1/0/0/1. Exits only on `force_reset` or `sys_rst_n`.
- Lock loss: `lk` = 0 in REL_IDELAY, REL_ADC or RUN causes a transition to HOLD.
  - `lock_loss_cnt` increments only if the loss occurs in RUN.
  - `retry_cnt` is not changed on lock loss.
- `force_reset`, sampled high in any state, causes a transition to HOLD and clears `retry_cnt`. It has priority over every other transition.
- Counters (cycle, stable, gap) are 32-bit and clear on every state entry.

## Timing
- During `sys_rst_n` low: state = HOLD, mmcm_rst = 1, idelay_rst = 1, adc_rst_n = 0, clk_ready = 0, fault = 0, retry_cnt = 0, lock_loss_cnt = 0, synchronizer flops = 0.
- HOLD count starts on the first edge after reset deassertion. Reset deassertion mid-operation restarts cleanly at HOLD.
- Latency from an `mmcm_locked` edge to its effect on `lk`: 2 cycles. The state change follows on the next edge, so lock loss reaches the outputs 3 edges after `mmcm_locked` falls.
- Best-case time from reset release to `clk_ready` = 1: RST_HOLD_CYC + 2 + LOCK_STABLE_CYC + 2·SEQ_GAP_CYC cycles, with `mmcm_locked` high from the start.
- `force_reset` to `mmcm_rst` = 1: 1 edge.

## Test plan
Parameters for all scenarios: RST_HOLD_CYC=4, LOCK_TIMEOUT_CYC=100, LOCK_STABLE_CYC=8, SEQ_GAP_CYC=4, MAX_RETRY=2.
- Nominal bring-up: `mmcm_locked` tied high from reset release.
  - `mmcm_rst` is high for 4 cycles.
  - `idelay_rst` falls 10 cycles after `mmcm_rst` falls.
  - `adc_rst_n` rises 4 cycles later.
  - `clk_ready` rises 4 cycles after that.
- Lock glitch in WAIT_LOCK: `mmcm_locked` high, then low for 1 cycle after 5 high cycles, then high.
  - Stable count restarts; REL_IDELAY is entered only after 8 further consecutive `lk`-high cycles.
- Timeout and fault: `mmcm_locked` held low.
  - After the first 100-cycle WAIT_LOCK, `retry_cnt` = 1 and state returns to HOLD.
  - After the second, `retry_cnt` = 2, `fault` = 1 and `mmcm_rst` = 1 permanently.
  - `force_reset` pulse → HOLD, `retry_cnt` = 0, `fault` = 0.
- Lock loss in RUN: drop `mmcm_locked` for 10 cycles.
  - Within 3 edges: `clk_ready` = 0, `adc_rst_n` = 0, `idelay_rst` = 1, `mmcm_rst` = 1, `lock_loss_cnt` = 1.
  - Full re-sequence follows once lock returns.
- Lock loss in REL_ADC: drop `mmcm_locked` while in REL_ADC.
  - Returns to HOLD with `lock_loss_cnt` unchanged at 0.
- Asynchronous reset mid-RUN: assert `sys_rst_n` low for a half cycle.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - Counters read 0; a fresh bring-up follows.
